// File: rtl/softplus_seq_ctrl.sv
// Streams a Q3.12 vector through the registered softplus unit into a destination buffer.
// Optional dt bias add on the operand path is enabled by defining SOFTPLUS_DT_BIAS_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef FRAC_BITS
`define FRAC_BITS 12
`endif

module softplus_seq_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  src_base,
    input  logic [ADDR_WIDTH-1:0]  dst_base,
    input  logic [LEN_WIDTH-1:0]   length,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [`DATA_WIDTH-1:0] rd_data,
    output logic [`DATA_WIDTH-1:0] sp_in,
    input  logic [`DATA_WIDTH-1:0] sp_out,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [`DATA_WIDTH-1:0] wr_data,
    input  logic                   wr_ready
`ifdef SOFTPLUS_DT_BIAS_EN
    ,
    input  logic [`DATA_WIDTH-1:0] bias
`endif
);

    localparam int DATA_W = `DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic [LEN_WIDTH-1:0]    rem;
    logic [ADDR_WIDTH-1:0]   dst_ptr;
    logic                    vld_p1, vld_p2;
    // Elements issued but not yet popped: in-flight reads + unit ops + FIFO entries.
    logic [2:0]              occ;
    logic [2:0]              occ_after_pop;
    logic [2:0]              fifo_cnt;
    logic [1:0]              head, tail;
    logic [ADDR_WIDTH-1:0]   fifo_addr [4];
    logic [DATA_W-1:0]       fifo_data [4];
    logic                    push, pop, issue, credit_ok;

`ifdef SOFTPLUS_DT_BIAS_EN
    function automatic logic [DATA_W-1:0] sat16(input logic signed [DATA_W:0] x);
        if (x[DATA_W] != x[DATA_W-1])
            return x[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return x[DATA_W-1:0];
    endfunction

    logic signed [DATA_W:0] biased_p1;

    always_comb begin
        biased_p1 = $signed({rd_data[DATA_W-1], rd_data}) + $signed({bias[DATA_W-1], bias});
        sp_in     = vld_p1 ? sat16(biased_p1) : '0;
    end
`else
    always_comb sp_in = vld_p1 ? rd_data : '0;
`endif

    always_comb begin
        push          = vld_p2;
        wr_en         = (fifo_cnt != 3'd0);
        pop           = wr_en && wr_ready;
        occ_after_pop = occ - {2'b00, pop};
        credit_ok     = (occ_after_pop < 3'd4);
        issue         = ((state == IDLE) && start && (length != '0)) ||
                        ((state == RUN) && credit_ok);
        wr_addr       = wr_en ? fifo_addr[head] : '0;
        wr_data       = wr_en ? fifo_data[head] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            rem      <= '0;
            dst_ptr  <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            occ      <= 3'd0;
            fifo_cnt <= 3'd0;
            head     <= 2'd0;
            tail     <= 2'd0;
        end else begin
            // p0 -> p1 -> p2: read issued, rd_data/sp_in valid, sp_out valid
            vld_p1   <= rd_en;
            vld_p2   <= vld_p1;
            rd_en    <= 1'b0;
            done     <= 1'b0;
            occ      <= occ_after_pop + {2'b00, issue};
            fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
            if (push) begin
                tail    <= tail + 2'd1;
                dst_ptr <= dst_ptr + ADDR_WIDTH'(1);
            end
            if (pop)
                head <= head + 2'd1;

            case (state)
                IDLE: if (start) begin
                    rem     <= length - LEN_WIDTH'(1);
                    rd_addr <= src_base;
                    dst_ptr <= dst_base;
                    busy    <= 1'b1;
                    if (length == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        rd_en <= 1'b1;
                        state <= (length == LEN_WIDTH'(1)) ? DRAIN : RUN;
                    end
                end
                RUN: if (credit_ok) begin
                    rd_en   <= 1'b1;
                    rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    rem     <= rem - LEN_WIDTH'(1);
                    if (rem == LEN_WIDTH'(1))
                        state <= DRAIN;
                end
                DRAIN: if (occ_after_pop == 3'd0) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= dst_ptr;
            fifo_data[tail] <= sp_out;
        end
    end

endmodule
